// File: rtl/note_seq_pkg.sv
// Shared state type and default sizes for the note sequence player and the
// piezo tone generator that consumes its notes.
package note_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_e;

    localparam int NOTE_W_DEF = 4;
    localparam int DEPTH_DEF  = 8;

    localparam logic [NOTE_W_DEF-1:0] NOTE_REST = '0;

endpackage

// File: rtl/tick_gen.sv
// Down-counter with synchronous clear; tick is high for the one cycle the count
// sits at zero, after which it reloads load_val.
module tick_gen #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clr || tick) begin
            cnt_d = load_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_seq_player.sv
// Note store and sequencer for the piezo path: previews a slot while idle and
// plays len slots, one per TICK_DIV clocks; NOTE_SEQ_GAP_EN adds a rest gap.
module note_seq_player
    import note_seq_pkg::*;
#(
    parameter int  NOTE_W   = NOTE_W_DEF,
    parameter int  DEPTH    = DEPTH_DEF,
    parameter int  TICK_DIV = 5000000,
    parameter int  GAP_DIV  = 500000,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [NOTE_W-1:0]       wr_note,
    input  logic                    load_en,
    input  logic [DEPTH*NOTE_W-1:0] load_bus,
    input  logic [IDX_W-1:0]        sel_idx,
    input  logic [IDX_W:0]          len,
    input  logic                    loop_en,
    input  logic                    play_start,
    input  logic                    play_stop,
    output logic [NOTE_W-1:0]       note_out,
    output logic [IDX_W-1:0]        play_idx,
    output logic                    busy,
    output logic                    done
);

    // One counter times both notes and gaps, so size it for the longer one.
    localparam int CNT_MAX = (GAP_DIV > TICK_DIV) ? GAP_DIV : TICK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [IDX_W:0]    LEN_MAX = (IDX_W+1)'(DEPTH);
    localparam logic [NOTE_W-1:0] REST    = NOTE_W'(NOTE_REST);

    state_e              state_q, state_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W:0]      len_q, len_d;
    logic                done_q, done_d;
    logic [NOTE_W-1:0]   slot_q [DEPTH];
    logic [NOTE_W-1:0]   slot_d [DEPTH];

    logic                tick;
    logic                tick_clr;
    logic                enter_gap;
    logic [CNT_W-1:0]    tick_load;
    logic [NOTE_W-1:0]   preview;
    logic                is_last;

`ifdef NOTE_SEQ_GAP_EN
    assign enter_gap = (state_q == PLAY);
`else
    assign enter_gap = 1'b0;
`endif

    // The reload value is the length of the phase that follows the current tick.
    assign tick_load = enter_gap ? CNT_W'(GAP_DIV - 1) : CNT_W'(TICK_DIV - 1);

    tick_gen #(
        .W (CNT_W)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .clr      (tick_clr),
        .load_val (tick_load),
        .tick     (tick)
    );

    assign preview = ({1'b0, sel_idx} < LEN_MAX) ? slot_q[sel_idx] : REST;
    assign is_last = ({1'b0, idx_q} == (len_q - 1'b1));

    always_comb begin
        slot_d = slot_q;
        if (load_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_d[k] = load_bus[k*NOTE_W +: NOTE_W];
            end
        end
        if (wr_en && ({1'b0, wr_idx} < LEN_MAX)) begin
            slot_d[wr_idx] = wr_note;
        end
    end

    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        idx_d    = idx_q;
        len_d    = len_q;
        done_d   = 1'b0;
        tick_clr = 1'b0;
        case (state_q)
            IDLE: begin
                note_d = preview;
                idx_d  = '0;
                if (play_start && !play_stop && (len != '0)) begin
                    state_d  = PLAY;
                    len_d    = (len > LEN_MAX) ? LEN_MAX : len;
                    note_d   = slot_q[0];
                    tick_clr = 1'b1;
                end
            end
            PLAY, GAP: begin
                if (play_stop) begin
                    state_d = IDLE;
                    note_d  = preview;
                    idx_d   = '0;
                end else if (tick && enter_gap) begin
                    state_d = GAP;
                    note_d  = REST;
                end else if (tick) begin
                    if (!is_last) begin
                        state_d = PLAY;
                        idx_d   = idx_q + 1'b1;
                        note_d  = slot_q[idx_q + 1'b1];
                    end else if (loop_en) begin
                        state_d = PLAY;
                        idx_d   = '0;
                        note_d  = slot_q[0];
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        note_d  = preview;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            note_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            slot_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            done_q  <= done_d;
            slot_q  <= slot_d;
        end
    end

    assign note_out = note_q;
    assign play_idx = idx_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_note_seq_player.sv
// Bench for note_seq_player: directed literal scenarios plus randomized traffic
// compared every cycle against a timeline model of the player.
module tb_note_seq_player;

    localparam int NOTE_W   = 4;
    localparam int DEPTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int GAP_DIV  = 2;
`ifdef NOTE_SEQ_GAP_EN
    localparam bit GAP_ON = 1'b1;
    localparam int LOOP_PERIOD = TICK_DIV + GAP_DIV;
`else
    localparam bit GAP_ON = 1'b0;
    localparam int LOOP_PERIOD = TICK_DIV;
`endif

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [3:0]  wr_note;
    logic        load_en;
    logic [31:0] load_bus;
    logic [2:0]  sel_idx;
    logic [3:0]  len;
    logic        loop_en;
    logic        play_start;
    logic        play_stop;
    logic [3:0]  note_out;
    logic [2:0]  play_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    note_seq_player #(
        .NOTE_W   (NOTE_W),
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .GAP_DIV  (GAP_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_note    (wr_note),
        .load_en    (load_en),
        .load_bus   (load_bus),
        .sel_idx    (sel_idx),
        .len        (len),
        .loop_en    (loop_en),
        .play_start (play_start),
        .play_stop  (play_stop),
        .note_out   (note_out),
        .play_idx   (play_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Reference model: a player that counts elapsed cycles within the current slot.
    logic [3:0]  m_mem [DEPTH] = '{default: '0};
    logic [3:0]  m_prev;
    bit          m_busy = 1'b0;
    bit          m_gap  = 1'b0;
    int          m_len  = 0;
    int          m_pos  = 0;
    int          m_age  = 0;
    logic [3:0]  exp_note = '0;
    logic [2:0]  exp_idx  = '0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
            m_busy = 1'b0; m_gap = 1'b0; m_pos = 0; m_age = 0; m_len = 0;
            exp_note = '0; exp_idx = '0; exp_busy = 1'b0; exp_done = 1'b0;
        end else begin
            m_prev   = m_mem[sel_idx];
            exp_done = 1'b0;
            if (!m_busy) begin
                exp_note = m_prev;
                if (play_start && !play_stop && len != 0) begin
                    m_busy = 1'b1;
                    m_len  = (int'(len) > DEPTH) ? DEPTH : int'(len);
                    m_pos  = 0; m_age = 0; m_gap = 1'b0;
                    exp_note = m_mem[0];
                end
            end else if (play_stop) begin
                m_busy   = 1'b0;
                exp_note = m_prev;
            end else begin
                m_age++;
                if (m_age == (m_gap ? GAP_DIV : TICK_DIV)) begin
                    m_age = 0;
                    if (GAP_ON && !m_gap) begin
                        m_gap    = 1'b1;
                        exp_note = '0;
                    end else begin
                        m_gap = 1'b0;
                        if (m_pos + 1 < m_len) begin
                            m_pos++;
                            exp_note = m_mem[m_pos];
                        end else if (loop_en) begin
                            m_pos    = 0;
                            exp_note = m_mem[0];
                        end else begin
                            m_busy   = 1'b0;
                            exp_done = 1'b1;
                            exp_note = m_prev;
                        end
                    end
                end
            end
            exp_busy = m_busy;
            exp_idx  = m_busy ? 3'(m_pos) : 3'd0;
            if (load_en) begin
                for (int k = 0; k < DEPTH; k++) m_mem[k] = load_bus[k*4 +: 4];
            end
            if (wr_en) m_mem[wr_idx] = wr_note;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_note_out", 32'(note_out), 32'(exp_note));
            check("model_play_idx", 32'(play_idx), 32'(exp_idx));
            check("model_busy", 32'(busy), 32'(exp_busy));
            check("model_done", 32'(done), 32'(exp_done));
        end
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_note = '0; load_en = 1'b0;
        load_bus = '0; sel_idx = '0; len = '0; loop_en = 1'b0;
        play_start = 1'b0; play_stop = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("reset_note", 32'(note_out), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_idx", 32'(play_idx), 0);
        check("reset_done", 32'(done), 0);
        reset = 1'b0;

        load_bus = 32'h8765_4321; load_en = 1'b1; sel_idx = 3'd5;
        cyc();
        load_en = 1'b0;
        cyc();
        check("preview_note", 32'(note_out), 6);
        check("preview_busy", 32'(busy), 0);

`ifndef NOTE_SEQ_GAP_EN
        len = 4'd3; play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("play3_note", 32'(note_out), 32'(1 + i / 4));
            check("play3_idx", 32'(play_idx), 32'(i / 4));
            check("play3_busy", 32'(busy), 1);
            cyc();
        end
        check("play3_done", 32'(done), 1);
        check("play3_busy_fall", 32'(busy), 0);
        check("play3_preview", 32'(note_out), 6);
        cyc();
        check("play3_done_pulse", 32'(done), 0);

        len = 4'd2; loop_en = 1'b1; play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("loop_note", 32'(note_out), 32'(((i / 4) % 2) + 1));
            check("loop_no_done", 32'(done), 0);
            cyc();
        end
        check("loop_note2", 32'(note_out), 2);
        cyc();
        loop_en = 1'b0;
        cyc();
        cyc();
        check("loop_last_note", 32'(note_out), 2);
        cyc();
        check("loop_end_done", 32'(done), 1);
        cyc();

        len = 4'd3; play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        repeat (9) cyc();
        check("stop_pre_note", 32'(note_out), 3);
        play_stop = 1'b1;
        cyc();
        play_stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_done", 32'(done), 0);
        check("stop_preview", 32'(note_out), 6);
`else
        len = 4'd2; loop_en = 1'b0; play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("gap_note", 32'(note_out), 32'((i < 4) ? 1 : (i < 6) ? 0 : (i < 10) ? 2 : 0));
            check("gap_busy", 32'(busy), 1);
            cyc();
        end
        check("gap_done", 32'(done), 1);
        check("gap_busy_fall", 32'(busy), 0);
        cyc();
`endif

        play_start = 1'b1; play_stop = 1'b1; len = 4'd3;
        cyc();
        play_start = 1'b0; play_stop = 1'b0;
        check("start_stop_busy", 32'(busy), 0);

        len = 4'd0; play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        check("len0_busy", 32'(busy), 0);
        check("len0_done", 32'(done), 0);

        len = 4'd1; loop_en = 1'b1; play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        check("wr_play_note0", 32'(note_out), 1);
        wr_en = 1'b1; wr_idx = 3'd0; wr_note = 4'd9;
        cyc();
        wr_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("wr_play_held", 32'(note_out), 1);
            cyc();
        end
        repeat (LOOP_PERIOD - 4) cyc();
        check("wr_play_next", 32'(note_out), 9);

        reset = 1'b1;
        #1;
        check("midreset_note", 32'(note_out), 0);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_idx", 32'(play_idx), 0);
        cyc();
        reset = 1'b0; loop_en = 1'b0; sel_idx = 3'd3;
        cyc();
        cyc();
        check("midreset_slot_cleared", 32'(note_out), 0);

        for (int n = 0; n < 4000; n++) begin
            wr_en    = ($urandom_range(0, 9) == 0);
            wr_idx   = 3'($urandom);
            wr_note  = 4'($urandom);
            load_en  = ($urandom_range(0, 49) == 0);
            load_bus = $urandom;
            if ($urandom_range(0, 7) == 0) sel_idx = 3'($urandom);
            if ($urandom_range(0, 15) == 0) len = 4'($urandom);
            if ($urandom_range(0, 31) == 0) loop_en = 1'($urandom);
            play_start = ($urandom_range(0, 19) == 0);
            play_stop  = ($urandom_range(0, 99) == 0);
            reset      = ($urandom_range(0, 499) == 0);
            cyc();
        end
        reset = 1'b0; play_start = 1'b0; play_stop = 1'b0; wr_en = 1'b0; load_en = 1'b0;
        cyc();
        cyc();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
